// File: rtl/wb_pipe_reg_pkg.sv
// rtl/wb_pipe_reg_pkg.sv - shared types and constants for the MEM->WB pipeline register
package wb_pipe_reg_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int TYPE_W_DEF = 7;

  // Instruction-type codes follow the RV32 major opcodes.
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] ALOPI  = 7'b0010011;
  localparam logic [6:0] ALOP   = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] INS_NOP = ALOPI;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef struct packed {
    logic                  ch_valid;
    logic [REG_AW_DEF-1:0] rd_addr;
    logic [XLEN_DEF-1:0]   rd_val;
    logic [TYPE_W_DEF-1:0] ins_type;
  } wb_slot_t;

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wb_slot_canon.sv
// rtl/wb_slot_canon.sv - per-slot bubble canonicalisation applied on capture
module wb_slot_canon
  import wb_pipe_reg_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                REG_AW   = 5,
  parameter int                TYPE_W   = 7,
  parameter logic [TYPE_W-1:0] NOP_TYPE = TYPE_W'(ALOPI)
) (
  input  logic              in_beat_valid,
  input  logic              in_ch_valid,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [XLEN-1:0]   in_rd_val,
  input  logic [TYPE_W-1:0] in_ins_type,
  output logic              out_ch_valid,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic [XLEN-1:0]   out_rd_val,
  output logic [TYPE_W-1:0] out_ins_type
);

  logic live;

  assign live = in_beat_valid & in_ch_valid;

  always_comb begin
    out_ch_valid = live;
    out_rd_addr  = '0;
    out_rd_val   = '0;
    out_ins_type = NOP_TYPE;
    if (live) begin
      out_rd_addr  = in_rd_addr;
      out_ins_type = in_ins_type;
      // x0 must never be written with a nonzero value.
      if (in_rd_addr != '0) out_rd_val = in_rd_val;
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - multi-slot MEM->WB register with skid buffer, pause and flush
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int                NUM_CH   = 2,
  parameter int                XLEN     = 32,
  parameter int                REG_AW   = 5,
  parameter int                TYPE_W   = 7,
  parameter logic [TYPE_W-1:0] NOP_TYPE = TYPE_W'(ALOPI)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH-1:0]        in_ch_valid,
  input  logic [NUM_CH*REG_AW-1:0] in_rd_addr,
  input  logic [NUM_CH*XLEN-1:0]   in_rd_val,
  input  logic [NUM_CH*TYPE_W-1:0] in_ins_type,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        out_ch_valid,
  output logic [NUM_CH*REG_AW-1:0] out_rd_addr,
  output logic [NUM_CH*XLEN-1:0]   out_rd_val,
  output logic [NUM_CH*TYPE_W-1:0] out_ins_type
);

  localparam logic [NUM_CH*TYPE_W-1:0] NOP_VEC = {NUM_CH{NOP_TYPE}};

  wb_state_e                state_q, state_d;
  logic [NUM_CH-1:0]        main_ch_q, main_ch_d, skid_ch_q, skid_ch_d;
  logic [NUM_CH*REG_AW-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
  logic [NUM_CH*XLEN-1:0]   main_val_q, main_val_d, skid_val_q, skid_val_d;
  logic [NUM_CH*TYPE_W-1:0] main_type_q, main_type_d, skid_type_q, skid_type_d;

  logic [NUM_CH-1:0]        canon_ch;
  logic [NUM_CH*REG_AW-1:0] canon_addr;
  logic [NUM_CH*XLEN-1:0]   canon_val;
  logic [NUM_CH*TYPE_W-1:0] canon_type;

  logic main_valid, skid_valid, in_xfer, out_xfer;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_canon
      wb_slot_canon #(
        .XLEN    (XLEN),
        .REG_AW  (REG_AW),
        .TYPE_W  (TYPE_W),
        .NOP_TYPE(NOP_TYPE)
      ) u_canon (
        .in_beat_valid(in_valid),
        .in_ch_valid  (in_ch_valid[g]),
        .in_rd_addr   (in_rd_addr[g*REG_AW +: REG_AW]),
        .in_rd_val    (in_rd_val[g*XLEN +: XLEN]),
        .in_ins_type  (in_ins_type[g*TYPE_W +: TYPE_W]),
        .out_ch_valid (canon_ch[g]),
        .out_rd_addr  (canon_addr[g*REG_AW +: REG_AW]),
        .out_rd_val   (canon_val[g*XLEN +: XLEN]),
        .out_ins_type (canon_type[g*TYPE_W +: TYPE_W])
      );
    end
  endgenerate

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign in_ready   = rdy_in & ~skid_valid & rst_in;
  assign out_valid  = main_valid & rdy_in;
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ch_d   = main_ch_q;
    main_addr_d = main_addr_q;
    main_val_d  = main_val_q;
    main_type_d = main_type_q;
    skid_ch_d   = skid_ch_q;
    skid_addr_d = skid_addr_q;
    skid_val_d  = skid_val_q;
    skid_type_d = skid_type_q;

    if (flush_in) begin
      state_d     = ST_EMPTY;
      main_ch_d   = '0;
      main_addr_d = '0;
      main_val_d  = '0;
      main_type_d = NOP_VEC;
      skid_ch_d   = '0;
      skid_addr_d = '0;
      skid_val_d  = '0;
      skid_type_d = NOP_VEC;
    end else if (rdy_in) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d     = ST_ONE;
            main_ch_d   = canon_ch;
            main_addr_d = canon_addr;
            main_val_d  = canon_val;
            main_type_d = canon_type;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d     = ST_TWO;
            skid_ch_d   = canon_ch;
            skid_addr_d = canon_addr;
            skid_val_d  = canon_val;
            skid_type_d = canon_type;
          end else if (in_xfer) begin
            main_ch_d   = canon_ch;
            main_addr_d = canon_addr;
            main_val_d  = canon_val;
            main_type_d = canon_type;
          end else if (out_xfer) begin
            // Drained main returns to bubble contents so idle outputs stay canonical.
            state_d     = ST_EMPTY;
            main_ch_d   = '0;
            main_addr_d = '0;
            main_val_d  = '0;
            main_type_d = NOP_VEC;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d     = ST_ONE;
            main_ch_d   = skid_ch_q;
            main_addr_d = skid_addr_q;
            main_val_d  = skid_val_q;
            main_type_d = skid_type_q;
            skid_ch_d   = '0;
            skid_addr_d = '0;
            skid_val_d  = '0;
            skid_type_d = NOP_VEC;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ch_d   = '0;
          main_addr_d = '0;
          main_val_d  = '0;
          main_type_d = NOP_VEC;
          skid_ch_d   = '0;
          skid_addr_d = '0;
          skid_val_d  = '0;
          skid_type_d = NOP_VEC;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_EMPTY;
      main_ch_q   <= '0;
      main_addr_q <= '0;
      main_val_q  <= '0;
      main_type_q <= NOP_VEC;
      skid_ch_q   <= '0;
      skid_addr_q <= '0;
      skid_val_q  <= '0;
      skid_type_q <= NOP_VEC;
    end else begin
      state_q     <= state_d;
      main_ch_q   <= main_ch_d;
      main_addr_q <= main_addr_d;
      main_val_q  <= main_val_d;
      main_type_q <= main_type_d;
      skid_ch_q   <= skid_ch_d;
      skid_addr_q <= skid_addr_d;
      skid_val_q  <= skid_val_d;
      skid_type_q <= skid_type_d;
    end
  end

  assign out_ch_valid = main_ch_q;
  assign out_rd_addr  = main_addr_q;
  assign out_rd_val   = main_val_q;
  assign out_ins_type = main_type_q;

  a_no_skid_without_main: assert property (
    @(posedge clk_in) disable iff (!rst_in) {main_valid, skid_valid} != 2'b01
  );

endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb/tb_wb_pipe_reg.sv - scoreboard bench for wb_pipe_reg
module tb_wb_pipe_reg;
  import wb_pipe_reg_pkg::*;

  localparam int NC = 2;
  localparam int AW = 5;
  localparam int XL = 32;
  localparam int TW = 7;
  localparam logic [TW-1:0] NOP = 7'b0010011;

  typedef struct packed {
    logic [NC-1:0]    ch;
    logic [NC*AW-1:0] addr;
    logic [NC*XL-1:0] val;
    logic [NC*TW-1:0] typ;
  } beat_t;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in, in_valid, in_ready, out_valid, out_ready;
  logic [NC-1:0]    in_ch_valid, out_ch_valid;
  logic [NC*AW-1:0] in_rd_addr, out_rd_addr;
  logic [NC*XL-1:0] in_rd_val, out_rd_val;
  logic [NC*TW-1:0] in_ins_type, out_ins_type;
  logic [NC*TW-1:0] nop_vec;

  beat_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  wb_pipe_reg #(
    .NUM_CH(NC), .XLEN(XL), .REG_AW(AW), .TYPE_W(TW), .NOP_TYPE(NOP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch_valid(in_ch_valid),
    .in_rd_addr(in_rd_addr), .in_rd_val(in_rd_val), .in_ins_type(in_ins_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch_valid(out_ch_valid),
    .out_rd_addr(out_rd_addr), .out_rd_val(out_rd_val), .out_ins_type(out_ins_type)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t expect_beat(input logic [NC-1:0] ch, input logic [NC*AW-1:0] a,
                                        input logic [NC*XL-1:0] v, input logic [NC*TW-1:0] t);
    beat_t b;
    b.ch   = ch;
    b.addr = '0;
    b.val  = '0;
    b.typ  = '0;
    for (int s = 0; s < NC; s++) begin
      b.typ[s*TW +: TW] = NOP;
      if (ch[s]) begin
        b.addr[s*AW +: AW] = a[s*AW +: AW];
        b.typ[s*TW +: TW]  = t[s*TW +: TW];
        if (a[s*AW +: AW] != 0) b.val[s*XL +: XL] = v[s*XL +: XL];
      end
    end
    return b;
  endfunction

  always @(negedge clk_in) begin
    logic exp_ir, exp_ov;
    if (!rst_in) begin
      q.delete();
      chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    end else begin
      exp_ir = rdy_in && (q.size() < 2);
      exp_ov = rdy_in && (q.size() > 0);
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      if (q.size() > 0) begin
        chk("out_ch_valid", {62'd0, out_ch_valid}, {62'd0, q[0].ch});
        chk("out_rd_addr", {54'd0, out_rd_addr}, {54'd0, q[0].addr});
        chk("out_rd_val", out_rd_val, q[0].val);
        chk("out_ins_type", {50'd0, out_ins_type}, {50'd0, q[0].typ});
      end
      if (flush_in) begin
        q.delete();
      end else begin
        if (exp_ov && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir)
          q.push_back(expect_beat(in_ch_valid, in_rd_addr, in_rd_val, in_ins_type));
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] ch, input logic [NC*AW-1:0] a,
                       input logic [NC*XL-1:0] v, input logic [NC*TW-1:0] t);
    in_valid    = 1'b1;
    in_ch_valid = ch;
    in_rd_addr  = a;
    in_rd_val   = v;
    in_ins_type = t;
  endtask

  task automatic drive_rand();
    drive(NC'($urandom), {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))},
          {$urandom, $urandom}, {ALOP, LOAD});
  endtask

  initial begin
    nop_vec = {NC{NOP}};
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_ch_valid = '0; in_rd_addr = '0; in_rd_val = '0; in_ins_type = '0;
    repeat (3) step();
    chk("rst_ins_type", {50'd0, out_ins_type}, {50'd0, nop_vec});
    chk("rst_rd_val", out_rd_val, 64'd0);
    chk("rst_rd_addr", {54'd0, out_rd_addr}, 64'd0);
    chk("rst_ch_valid", {62'd0, out_ch_valid}, 64'd0);
    rst_in = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      drive(2'b11, {5'(i + 9), 5'(i + 1)}, {$urandom, 32'h100 + 32'(i)}, {ALOP, LOAD});
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    out_ready = 1'b0;
    drive_rand(); step();
    drive_rand(); step();
    drive_rand(); step();
    chk("backpressure_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    out_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (3) step();

    drive(2'b10, {5'd0, 5'd7}, {32'hDEADBEEF, 32'h12345678}, {ALOP, LOAD});
    step();
    in_valid = 1'b0;
    chk("canon_slot1_val", {32'd0, out_rd_val[63:32]}, 64'd0);
    chk("canon_slot0_val", {32'd0, out_rd_val[31:0]}, 64'd0);
    chk("canon_slot0_addr", {59'd0, out_rd_addr[4:0]}, 64'd0);
    chk("canon_slot0_type", {57'd0, out_ins_type[6:0]}, {57'd0, NOP});
    repeat (2) step();

    out_ready = 1'b0;
    drive_rand(); step();
    drive_rand(); step();
    rdy_in = 1'b0;
    drive_rand();
    repeat (4) step();
    chk("pause_out_valid", {63'd0, out_valid}, 64'd0);
    rdy_in = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    repeat (4) step();

    out_ready = 1'b0;
    drive_rand(); step();
    drive_rand(); step();
    drive_rand(); flush_in = 1'b1; step();
    flush_in = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    repeat (3) step();

    drive_rand(); step();
    in_valid = 1'b0; rdy_in = 1'b0; flush_in = 1'b1; step();
    flush_in = 1'b0; rdy_in = 1'b1; step();
    chk("flush_paused_out_valid", {63'd0, out_valid}, 64'd0);

    out_ready = 1'b0;
    drive_rand(); step();
    drive_rand(); step();
    in_valid = 1'b0;
    rst_in = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_ch_valid", {62'd0, out_ch_valid}, 64'd0);
    chk("midrst_ins_type", {50'd0, out_ins_type}, {50'd0, nop_vec});
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    rst_in = 1'b1;
    step();

    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_ch_valid = NC'($urandom);
      for (int s = 0; s < NC; s++)
        in_rd_addr[s*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      in_rd_val   = {$urandom, $urandom};
      in_ins_type = {7'($urandom), 7'($urandom)};
      out_ready   = ($urandom_range(0, 2) != 0);
      rdy_in      = ($urandom_range(0, 9) != 0);
      flush_in    = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid = 1'b0; flush_in = 1'b0; rdy_in = 1'b1; out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
